// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin scheduler for one shared pipelined 32x32 multiplier
module mul_sched #(
  parameter int LAT  = 3,
  parameter int TAGW = 5,
  parameter int OBUF = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_A,
  input  logic [31:0]     req0_B,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_A,
  input  logic [31:0]     req1_B,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     mul_A,
  output logic [31:0]     mul_B,
  input  logic [31:0]     mul_P,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_P,
  output logic [TAGW-1:0] res_tag,
  output logic            res_src
);

  localparam int CW = $clog2(OBUF + 1);
  localparam int PW = (OBUF > 1) ? $clog2(OBUF) : 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(OBUF);
  localparam logic [PW-1:0] SLOT_LAST  = PW'(OBUF - 1);

  // Ops in flight plus results waiting in the FIFO.
  logic [CW-1:0]   credit_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic            rr_ptr;

  logic [LAT-1:0]  trk_v;
  logic [TAGW-1:0] trk_tag [LAT];
  logic            trk_src [LAT];

  logic [31:0]     fifo_p   [OBUF];
  logic [TAGW-1:0] fifo_tag [OBUF];
  logic            fifo_src [OBUF];

  logic            issue_ok;
  logic            grant0;
  logic            grant1;
  logic            issue;
  logic            pop;
  logic            capture;
  logic            fifo_nonempty;
  logic [31:0]     grant_A;
  logic [31:0]     grant_B;
  logic [TAGW-1:0] grant_tag;

  // Grant at most one requester per cycle while credit remains; the pointer breaks ties.
  always_comb begin
    issue_ok  = !RST && !flush && (credit_cnt < CREDIT_MAX);
    grant0    = issue_ok && req0_valid && (!req1_valid || !rr_ptr);
    grant1    = issue_ok && req1_valid && (!req0_valid ||  rr_ptr);
    issue     = grant0 || grant1;
    grant_A   = grant1 ? req1_A   : req0_A;
    grant_B   = grant1 ? req1_B   : req0_B;
    grant_tag = grant1 ? req1_tag : req0_tag;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Result port presents the FIFO head; it reads as zero whenever the FIFO is empty.
  always_comb begin
    fifo_nonempty = (fifo_cnt != '0);
    res_valid     = fifo_nonempty;
    res_P         = '0;
    res_tag       = '0;
    res_src       = 1'b0;
    if (fifo_nonempty) begin
      res_P   = fifo_p[rd_ptr];
      res_tag = fifo_tag[rd_ptr];
      res_src = fifo_src[rd_ptr];
    end
    pop     = fifo_nonempty && res_ready;
    capture = trk_v[LAT-1];
  end

  // Operand registers drive the multiplier and hold their value between issues.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_A <= '0;
      mul_B <= '0;
    end else if (issue) begin
      mul_A <= grant_A;
      mul_B <= grant_B;
    end
  end

  // After a grant the tie-break favours the requester that was not served.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (issue) begin
      rr_ptr <= grant0;
    end
  end

  // Valid bits of ops in flight; clearing them makes late products of killed ops vanish.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      trk_v <= '0;
    end else begin
      trk_v[0] <= issue;
      for (int i = 1; i < LAT; i++) begin
        trk_v[i] <= trk_v[i-1];
      end
    end
  end

  // Tag and source ride alongside the valid bits and only matter where a valid bit is set.
  always_ff @(posedge CLK) begin
    trk_tag[0] <= grant_tag;
    trk_src[0] <= grant1;
    for (int i = 1; i < LAT; i++) begin
      trk_tag[i] <= trk_tag[i-1];
      trk_src[i] <= trk_src[i-1];
    end
  end

  // Result slots are written when the tracked op's product is on mul_P.
  always_ff @(posedge CLK) begin
    if (!RST && !flush && capture) begin
      fifo_p[wr_ptr]   <= mul_P;
      fifo_tag[wr_ptr] <= trk_tag[LAT-1];
      fifo_src[wr_ptr] <= trk_src[LAT-1];
    end
  end

  // FIFO pointers and occupancy; credit keeps writes from ever meeting a full FIFO.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= (wr_ptr == SLOT_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == SLOT_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credit grows on issue and shrinks on pop; flush returns every credit at once.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      credit_cnt <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   credit_cnt <= credit_cnt + 1'b1;
        2'b01:   credit_cnt <= credit_cnt - 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule
